// File: rtl/alu_exec_controller_if.sv
// Instruction handshake and ALU operand/result bus
// for the ALU issue/writeback controller.
interface alu_exec_controller_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH+7:0] Instr;
  logic             Instr_Valid;
  logic             Instr_Ready;
  logic [WIDTH-1:0] ALU_A;
  logic [WIDTH-1:0] ALU_B;
  logic [2:0]       ALU_OP;
  logic [WIDTH-1:0] ALU_Result;
  logic [3:0]       ALU_NZCV;

  modport master (
    output Instr,
    output Instr_Valid,
    input  Instr_Ready,
    input  ALU_A,
    input  ALU_B,
    input  ALU_OP,
    output ALU_Result,
    output ALU_NZCV
  );

  modport slave (
    input  Instr,
    input  Instr_Valid,
    output Instr_Ready,
    output ALU_A,
    output ALU_B,
    output ALU_OP,
    input  ALU_Result,
    input  ALU_NZCV
  );
endinterface

// File: rtl/alu_exec_controller.sv
// Issue/writeback sequencer for the 8-bit ALU:
// IDLE -> EXEC -> WB, one instruction per 3 cycles.
module alu_exec_controller #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_exec_controller_if.slave bus,
  output logic [3:0]       Flags,
  output logic             Done,
  input  logic [1:0]       Dbg_Sel,
  output logic [WIDTH-1:0] Dbg_Data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] rf [4];
  logic [1:0]       rd_q;
  logic [WIDTH-1:0] res_q;
  logic [3:0]       nzcv_q;

  logic [2:0]       op;
  logic             imm_en;
  logic [1:0]       rd;
  logic [1:0]       rs;
  logic [WIDTH-1:0] imm;
  logic             accept;

  assign op     = bus.Instr[WIDTH+7:WIDTH+5];
  assign imm_en = bus.Instr[WIDTH+4];
  assign rd     = bus.Instr[WIDTH+3:WIDTH+2];
  assign rs     = bus.Instr[WIDTH+1:WIDTH];
  assign imm    = bus.Instr[WIDTH-1:0];

  assign bus.Instr_Ready = (state == IDLE);
  assign accept   = bus.Instr_Valid && (state == IDLE);
  assign Dbg_Data = rf[Dbg_Sel];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_q       <= '0;
      res_q      <= '0;
      nzcv_q     <= '0;
      Flags      <= '0;
      Done       <= 1'b0;
      bus.ALU_A  <= '0;
      bus.ALU_B  <= '0;
      bus.ALU_OP <= '0;
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else begin
      Done <= 1'b0;
      unique case (1'b1)
        state == IDLE: begin
          if (accept) begin
            // operands read before any write, so Rd==Rs sees the old value
            bus.ALU_A  <= rf[rd];
            bus.ALU_B  <= imm_en ? imm : rf[rs];
            bus.ALU_OP <= op;
            rd_q       <= rd;
            state      <= EXEC;
          end
        end
        state == EXEC: begin
          res_q  <= bus.ALU_Result;
          nzcv_q <= bus.ALU_NZCV;
          state  <= WB;
        end
        state == WB: begin
          rf[rd_q] <= res_q;
          Flags    <= nzcv_q;
          Done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_controller.sv
// Directed bench for alu_exec_controller driven
// through an adder stub ALU.
module tb_alu_exec_controller;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       Flags;
  logic             Done;
  logic [1:0]       Dbg_Sel;
  logic [WIDTH-1:0] Dbg_Data;

  int checks   = 0;
  int failures = 0;

  alu_exec_controller_if #(.WIDTH(WIDTH)) bus ();

  alu_exec_controller #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .Flags    (Flags),
    .Done     (Done),
    .Dbg_Sel  (Dbg_Sel),
    .Dbg_Data (Dbg_Data)
  );

  always #5 clk = ~clk;

  logic [WIDTH:0] sum;
  always_comb begin
    sum = {1'b0, bus.ALU_A} + {1'b0, bus.ALU_B};
    bus.ALU_Result = sum[WIDTH-1:0];
    bus.ALU_NZCV = {sum[WIDTH-1],
                    sum[WIDTH-1:0] == '0,
                    sum[WIDTH],
                    (bus.ALU_A[WIDTH-1] == bus.ALU_B[WIDTH-1]) &&
                    (sum[WIDTH-1] != bus.ALU_A[WIDTH-1])};
  end

  function automatic logic [WIDTH+7:0] mk(
    input logic [2:0] op, input logic ie,
    input logic [1:0] rd, input logic [1:0] rs,
    input logic [WIDTH-1:0] imm);
    return {op, ie, rd, rs, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag,
                           input logic [1:0] sel,
                           input logic [WIDTH-1:0] exp);
    Dbg_Sel = sel;
    #1;
    check(tag, 16'(Dbg_Data), 16'(exp));
  endtask

  // accept one instruction and run it to its Done cycle
  task automatic run(input string tag, input logic [WIDTH+7:0] ins);
    bus.Instr = ins;
    bus.Instr_Valid = 1'b1;
    tick();
    bus.Instr_Valid = 1'b0;
    tick();
    tick();
    check({tag, "_done"}, 16'(Done), 16'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.Instr = '0;
    bus.Instr_Valid = 1'b0;
    Dbg_Sel = 2'd0;

    // reset then idle
    tick();
    tick();
    check("rst_flags", 16'(Flags), 16'h0);
    check("rst_done", 16'(Done), 16'h0);
    check("rst_a", 16'(bus.ALU_A), 16'h0);
    check("rst_b", 16'(bus.ALU_B), 16'h0);
    check("rst_op", 16'(bus.ALU_OP), 16'h0);
    for (int i = 0; i < 4; i++)
      check_reg("rst_rf", 2'(i), 8'h00);
    rst_n = 1'b1;
    tick();
    check("idle_ready", 16'(bus.Instr_Ready), 16'h1);
    tick();
    check("idle_done", 16'(Done), 16'h0);
    check("idle_ready2", 16'(bus.Instr_Ready), 16'h1);

    // immediate load R1 = 0x05
    bus.Instr = mk(3'b000, 1'b1, 2'd1, 2'd0, 8'h05);
    bus.Instr_Valid = 1'b1;
    tick();
    bus.Instr_Valid = 1'b0;
    check("imm_a", 16'(bus.ALU_A), 16'h00);
    check("imm_b", 16'(bus.ALU_B), 16'h05);
    check("imm_op", 16'(bus.ALU_OP), 16'h0);
    check("imm_ready_n", 16'(bus.Instr_Ready), 16'h0);
    check("imm_done_n", 16'(Done), 16'h0);
    tick();
    check("imm_done_n1", 16'(Done), 16'h0);
    tick();
    check("imm_done", 16'(Done), 16'h1);
    check("imm_ready_done", 16'(bus.Instr_Ready), 16'h1);
    check("imm_flags", 16'(Flags), 16'h0);
    check_reg("imm_r1", 2'd1, 8'h05);
    tick();
    check("imm_done_drop", 16'(Done), 16'h0);

    // build R1 = 0xFF, R2 = 0x01, then R1 += R2
    run("set_r1", mk(3'b000, 1'b1, 2'd1, 2'd0, 8'hFA));
    check_reg("set_r1_val", 2'd1, 8'hFF);
    run("set_r2", mk(3'b000, 1'b1, 2'd2, 2'd0, 8'h01));
    check_reg("set_r2_val", 2'd2, 8'h01);
    run("add_rr", mk(3'b000, 1'b0, 2'd1, 2'd2, 8'h00));
    check_reg("add_r1", 2'd1, 8'h00);
    check("add_flags", 16'(Flags), 16'b0110);

    // back-to-back accepts with Instr_Valid held high
    bus.Instr = mk(3'b000, 1'b1, 2'd0, 2'd0, 8'h80);
    bus.Instr_Valid = 1'b1;
    tick();
    check("b2b_a1", 16'(bus.ALU_A), 16'h00);
    check("b2b_ready1", 16'(bus.Instr_Ready), 16'h0);
    tick();
    tick();
    check("b2b_done1", 16'(Done), 16'h1);
    check("b2b_ready_done", 16'(bus.Instr_Ready), 16'h1);
    check_reg("b2b_r0_1", 2'd0, 8'h80);
    check("b2b_flags1", 16'(Flags), 16'b1000);
    tick();
    bus.Instr_Valid = 1'b0;
    check("b2b_a2", 16'(bus.ALU_A), 16'h80);
    check("b2b_b2", 16'(bus.ALU_B), 16'h80);
    check("b2b_ready2", 16'(bus.Instr_Ready), 16'h0);
    tick();
    tick();
    check("b2b_done2", 16'(Done), 16'h1);
    check_reg("b2b_r0_2", 2'd0, 8'h00);
    check("b2b_flags2", 16'(Flags), 16'b0111);

    // Instr changes while busy are ignored
    tick();
    bus.Instr = mk(3'b101, 1'b1, 2'd2, 2'd0, 8'h33);
    bus.Instr_Valid = 1'b1;
    tick();
    bus.Instr = mk(3'b111, 1'b0, 2'd3, 2'd1, 8'hAA);
    check("ign_ready0", 16'(bus.Instr_Ready), 16'h0);
    check("ign_a0", 16'(bus.ALU_A), 16'h01);
    check("ign_b0", 16'(bus.ALU_B), 16'h33);
    check("ign_op0", 16'(bus.ALU_OP), 16'h5);
    tick();
    bus.Instr = mk(3'b010, 1'b1, 2'd0, 2'd3, 8'h55);
    check("ign_ready1", 16'(bus.Instr_Ready), 16'h0);
    check("ign_b1", 16'(bus.ALU_B), 16'h33);
    check("ign_op1", 16'(bus.ALU_OP), 16'h5);
    tick();
    bus.Instr_Valid = 1'b0;
    check("ign_ready2", 16'(bus.Instr_Ready), 16'h1);
    check("ign_done", 16'(Done), 16'h1);
    check_reg("ign_r2", 2'd2, 8'h34);
    check_reg("ign_r3", 2'd3, 8'h00);
    check("ign_flags", 16'(Flags), 16'h0);
    tick();
    check("hold_a", 16'(bus.ALU_A), 16'h01);
    check("hold_op", 16'(bus.ALU_OP), 16'h5);

    // reset during EXEC aborts the instruction
    bus.Instr = mk(3'b000, 1'b1, 2'd3, 2'd0, 8'h7F);
    bus.Instr_Valid = 1'b1;
    tick();
    bus.Instr_Valid = 1'b0;
    check("rx_b", 16'(bus.ALU_B), 16'h7F);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rx_done0", 16'(Done), 16'h0);
    tick();
    check("rx_done1", 16'(Done), 16'h0);
    tick();
    check("rx_done2", 16'(Done), 16'h0);
    check("rx_ready", 16'(bus.Instr_Ready), 16'h1);
    check("rx_flags", 16'(Flags), 16'h0);
    check_reg("rx_r3", 2'd3, 8'h00);
    check_reg("rx_r2", 2'd2, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_controller.md
# alu_exec_controller

Upstream issue/writeback stage for the 8-bit ALU. It accepts one decoded instruction word per handshake and reads operands from a local 4-entry register file. It drives the ALU operand and opcode inputs from registers, then captures the ALU `Result` and `NZCV` outputs. Finally it writes the result back to the destination register and latches the flags. The block is a 3-state sequencer and processes one instruction every 3 cycles.

## Interface
- `WIDTH`, default 8: datapath width. Must equal the ALU operand width.
- `clk`  in  1  — the only clock; all state updates on the rising edge.
- `rst_n`  in  1  — reset, synchronous and active-low.
- `Instr`  in  WIDTH+8  — instruction word:
  - [WIDTH+7:WIDTH+5] OP_Code
  - [WIDTH+4] Imm_En
  - [WIDTH+3:WIDTH+2] Rd
  - [WIDTH+1:WIDTH] Rs
  - [WIDTH-1:0] Imm
- `Instr_Valid`  in  1  — `Instr` is valid this cycle.
- `Instr_Ready`  out  1  — block can accept an instruction this cycle.
- `ALU_A`  out  WIDTH  — registered operand A to the ALU.
- `ALU_B`  out  WIDTH  — registered operand B to the ALU.
- `ALU_OP`  out  3  — registered opcode to the ALU.
- `ALU_Result`  in  WIDTH  — combinational result from the ALU.
- `ALU_NZCV`  in  4  — combinational flags from the ALU.
- `Flags`  out  4  — architectural NZCV register.
- `Done`  out  1  — one-cycle pulse: writeback completed.
- `Dbg_Sel`  in  2  — register file debug read select.
- `Dbg_Data`  out  WIDTH  — combinational read of R[`Dbg_Sel`].

## Operation
- States:
  - IDLE: `Instr_Ready`=1.
  - EXEC: ALU inputs stable; ALU output settles.
  - WB: captured result held.
- Transitions:
  - IDLE→EXEC on `Instr_Valid`&&`Instr_Ready`.
  - EXEC→WB unconditionally.
  - WB→IDLE unconditionally.
  - IDLE holds while `Instr_Valid`=0.
- On the accept edge:
  - `ALU_A`←R[Rd].
  - `ALU_B`←(Imm_En ? Imm : R[Rs]).
  - `ALU_OP`←OP_Code.
  - Rd is latched internally.
- EXEC→WB edge: `Res_q`←`ALU_Result`, `NZCV_q`←`ALU_NZCV`.
- WB→IDLE edge: R[Rd_q]←`Res_q`, `Flags`←`NZCV_q`, `Done`←1.
- `Done` is 0 on every other edge.
- Every instruction writes R[Rd] and `Flags`. No opcode suppresses writeback; the block is opcode-agnostic.
- `ALU_A`, `ALU_B` and `ALU_OP` hold their values outside the accept edge. They do not return to 0 after an instruction.
- `Instr` is ignored whenever `Instr_Ready`=0. The upstream side may hold or change it freely during that time.
- Rd==Rs is legal. The operand is the pre-instruction value.
- Register file: 4×WIDTH, one write port (WB only), two operand reads plus one debug read, all combinational.

## Timing
- Reset values (`rst_n`=0 at an edge): state=IDLE, R0–R3=0, `Flags`=0, `ALU_A`=`ALU_B`=0, `ALU_OP`=0, `Res_q`=0, `NZCV_q`=0, `Done`=0.
- `Instr_Ready`=1 in the first cycle after reset is released.
- Reset mid-instruction (EXEC or WB) aborts it: no register or `Flags` write, no `Done` pulse.
- Latency: instruction accepted at edge N.
  - ALU inputs valid from N.
  - Result captured at N+1.
  - R[Rd], `Flags` and `Done` update at N+2.
- `Instr_Ready` is 0 during EXEC and WB. It is 1 in the cycle where `Done`=1.
- Back-to-back accept is allowed in the `Done` cycle. That accept (edge N+3) reads the already-updated register file, so there is no hazard and no forwarding is needed.
- Peak throughput is 1 instruction per 3 cycles.
- `Dbg_Data` reflects a write starting on the cycle after the WB edge.

## Test plan
The bench drives the block from a stub ALU: `ALU_Result`=`ALU_A`+`ALU_B` (WIDTH bits). `ALU_NZCV` = {msb, zero, carry-out, signed overflow}, for every opcode.

- Reset then idle: hold `rst_n`=0 for 2 cycles → all outputs at reset values; `Instr_Ready`=1 after release; no `Done` while `Instr_Valid`=0.
- Immediate load: accept {op=000, Imm_En=1, Rd=1, Imm=0x05} → `ALU_A`=0x00, `ALU_B`=0x05 from edge N; `Done` at N+2; R1=0x05; `Flags`=0000.
- Register add with carry: R1=0xFF, R2=0x01; accept {Imm_En=0, Rd=1, Rs=2} → R1=0x00, `Flags`=0110 (Z, C).
- Back-to-back: raise `Instr_Valid` continuously with {Rd=0, Imm=0x80} twice →
  - accepts at N and N+3;
  - second `ALU_A`=0x80;
  - R0=0x00 and `Flags`=0111 after the second `Done`.
- Ignored input: change `Instr` during EXEC/WB → captured operands unchanged; `Instr_Ready`=0 for exactly 2 cycles.
- Reset in EXEC: accept {Rd=3, Imm=0x7F}, assert `rst_n`=0 at N+1 → R3=0, no `Done`, `Flags`=0000.
